// File: rtl/mlp_weight_loader_if.sv
// mlp_weight_loader_if: host weight stream into the loader.
// The host drives data/valid/last and the loader answers with ready.
interface mlp_weight_loader_if;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;

    modport master (output s_tdata, s_tvalid, s_tlast, input s_tready);
    modport slave  (input s_tdata, s_tvalid, s_tlast, output s_tready);
endinterface

// File: rtl/mlp_weight_loader.sv
// mlp_weight_loader: tags host weights with layer/group/neuron IDs and frames the load with
// load/run mode writes. Define WLOAD_TLAST_CHECK_EN to flag s_tlast framing errors on err.
module mlp_weight_loader #(
    parameter int unsigned N_LAYERS  = 4,
    parameter logic [31:0] L_GROUPS  = 32'h01_03_03_01,
    parameter logic [31:0] L_NEURONS = 32'h03_14_14_14,
    parameter logic [31:0] L_INPUTS  = 32'h07_07_07_04,
    parameter int unsigned SETTLE    = 20
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               start,
    mlp_weight_loader_if.slave host,
    output logic [31:0]        w_tdata,
    output logic [15:0]        set_in,
    output logic               set_en,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam logic [1:0]  LastLayer  = 2'(N_LAYERS - 1);
    localparam logic [15:0] SettleLast = 16'(SETTLE - 1);
    localparam logic [15:0] ModeLoad   = 16'd2;
    localparam logic [15:0] ModeRun    = 16'd1;

    typedef enum logic [2:0] {
        StIdle, StSetLoad, StPreGap, StWord, StNgap, StSettle, StSetRun
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  layer_q, layer_d;
    logic [7:0]  group_q, group_d;
    logic [4:0]  neuron_q, neuron_d;
    logic [7:0]  input_q, input_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] w_tdata_q, w_tdata_d;
    logic [15:0] set_in_q, set_in_d;
    logic        set_en_q, set_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  groups_cur, neurons_cur, inputs_cur;
    logic        last_input, last_neuron, last_group, last_layer, last_word;
    logic [15:0] word_id;

    assign groups_cur  = L_GROUPS[{layer_q, 3'b000} +: 8];
    assign neurons_cur = L_NEURONS[{layer_q, 3'b000} +: 8];
    assign inputs_cur  = L_INPUTS[{layer_q, 3'b000} +: 8];

    assign last_input  = (input_q == inputs_cur - 8'd1);
    assign last_neuron = ({3'b000, neuron_q} == neurons_cur - 8'd1);
    assign last_group  = (group_q == groups_cur - 8'd1);
    assign last_layer  = (layer_q == LastLayer);
    assign last_word   = last_input & last_neuron & last_group & last_layer;

    assign word_id = (16'd256 << layer_q) + {3'b000, group_q, 5'b00000} + {11'd0, neuron_q};

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        group_d   = group_q;
        neuron_d  = neuron_q;
        input_d   = input_q;
        cnt_d     = cnt_q;
        w_tdata_d = 32'd0;
        set_in_d  = 16'd0;
        set_en_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSetLoad;
                    set_en_d = 1'b1;
                    set_in_d = ModeLoad;
                    err_d    = 1'b0;
                    layer_d  = '0;
                    group_d  = '0;
                    neuron_d = '0;
                    input_d  = '0;
                end
            end
            StSetLoad: begin
                state_d = StPreGap;
                cnt_d   = '0;
            end
            StPreGap: begin
                if (cnt_q == 16'd1) state_d = StWord;
                else                cnt_d   = cnt_q + 16'd1;
            end
            StWord: begin
                if (host.s_tvalid) begin
                    w_tdata_d = {word_id, host.s_tdata};
`ifdef WLOAD_TLAST_CHECK_EN
                    err_d = err_q | (host.s_tlast ^ last_word);
`endif
                    if (last_input) begin
                        input_d = '0;
                        state_d = StNgap;
                    end else begin
                        input_d = input_q + 8'd1;
                    end
                end
            end
            StNgap: begin
                // Odometer advance: neuron, then group, then layer; full wrap ends the table.
                state_d = StWord;
                if (!last_neuron) begin
                    neuron_d = neuron_q + 5'd1;
                end else begin
                    neuron_d = '0;
                    if (!last_group) begin
                        group_d = group_q + 8'd1;
                    end else begin
                        group_d = '0;
                        if (!last_layer) begin
                            layer_d = layer_q + 2'd1;
                        end else begin
                            layer_d = '0;
                            cnt_d   = '0;
                            state_d = StSettle;
                        end
                    end
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d  = StSetRun;
                    set_en_d = 1'b1;
                    set_in_d = ModeRun;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSetRun: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= StIdle;
            layer_q   <= '0;
            group_q   <= '0;
            neuron_q  <= '0;
            input_q   <= '0;
            cnt_q     <= '0;
            w_tdata_q <= '0;
            set_in_q  <= '0;
            set_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            group_q   <= group_d;
            neuron_q  <= neuron_d;
            input_q   <= input_d;
            cnt_q     <= cnt_d;
            w_tdata_q <= w_tdata_d;
            set_in_q  <= set_in_d;
            set_en_q  <= set_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef WLOAD_TLAST_CHECK_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`else
    logic unused_tlast;
    logic unused_err_d;
    assign err_q        = 1'b0;
    assign err          = 1'b0;
    assign unused_tlast = host.s_tlast;
    assign unused_err_d = err_d;
`endif

    assign host.s_tready = (state_q == StWord);
    assign w_tdata       = w_tdata_q;
    assign set_in        = set_in_q;
    assign set_en        = set_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mlp_weight_loader.sv
// tb_mlp_weight_loader: directed bench for mlp_weight_loader, default table plus a
// one-word table instance.
module tb_mlp_weight_loader;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 aclk = ~aclk;

`ifdef WLOAD_TLAST_CHECK_EN
    localparam bit TlastChk = 1'b1;
`else
    localparam bit TlastChk = 1'b0;
`endif

    mlp_weight_loader_if host ();
    mlp_weight_loader_if host2 ();

    logic [31:0] w_tdata, w_tdata2;
    logic [15:0] set_in, set_in2;
    logic        set_en, busy, done, err;
    logic        set_en2, busy2, done2, err2;

    mlp_weight_loader dut (
        .aclk    (aclk),
        .areset  (areset),
        .start   (start),
        .host    (host.slave),
        .w_tdata (w_tdata),
        .set_in  (set_in),
        .set_en  (set_en),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    mlp_weight_loader #(
        .N_LAYERS  (1),
        .L_GROUPS  (32'h01),
        .L_NEURONS (32'h01),
        .L_INPUTS  (32'h01),
        .SETTLE    (20)
    ) u_small (
        .aclk    (aclk),
        .areset  (areset),
        .start   (start2),
        .host    (host2.slave),
        .w_tdata (w_tdata2),
        .set_in  (set_in2),
        .set_en  (set_en2),
        .busy    (busy2),
        .done    (done2),
        .err     (err2)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] id_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] val_of(input int k);
        return 16'((k * 613) ^ 32'h5A3C);
    endfunction

    // One load on the default instance; start is sampled at edge t0, c counts cycles after it.
    task automatic run_load(input int stall_pct, input int extra_start, input int bad_tlast,
                            input int abort_at, output int done_cyc, output int n_stall);
        int acc = 0;
        int seen = 0;
        int c = 0;
        int first_rdy = -1;
        int set_bad = 0;
        bit stalled = 1'b0;
        bit accept;
        logic [31:0] last_w = '0;
        done_cyc = -1;
        n_stall = 0;
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        while (done_cyc < 0 && c < 4000) begin
            @(negedge aclk);
            start = 1'b0;
            c++;
            if (c == 1)
                check("load_mode", 64'({set_en, set_in, err}), 64'({1'b1, 16'd2, 1'b0}));
            if (host.s_tready && first_rdy < 0) first_rdy = c;
            if (stalled) begin
                check("stall_zero", 64'(w_tdata), 64'd0);
            end else if (w_tdata != 32'd0) begin
                if (seen < 941)
                    check("word", 64'(w_tdata), 64'({id_q[seen], val_of(seen)}));
                else
                    check("word_overrun", 64'(seen), 64'd940);
                if (set_en) set_bad++;
                if (bad_tlast >= 0 && seen == bad_tlast - 1)
                    check("err_before", 64'(err), 64'd0);
                if (bad_tlast >= 0 && seen == bad_tlast)
                    check("err_after", 64'(err), 64'(TlastChk));
                last_w = w_tdata;
                seen++;
            end
            if (stall_pct == 0 && c == 9) check("ngap_zero", 64'(w_tdata), 64'd0);
            if (stall_pct == 0 && c == 10) check("second_id", 64'(w_tdata[31:16]), 64'h0101);
            if (set_en && c != 1 && !done) set_bad++;
            if (abort_at >= 0 && seen == abort_at) begin
                areset = 1'b1;
                #1;
                check("reset_async", 64'({w_tdata, set_in, set_en, host.s_tready, busy, done,
                                          err}), 64'd0);
                return;
            end
            if (done) begin
                done_cyc = c;
                check("run_mode", 64'({set_en, set_in}), 64'({1'b1, 16'd1}));
                check("err_at_done", 64'(err), 64'(bad_tlast >= 0 ? TlastChk : 1'b0));
            end
            stalled = 1'b0;
            host.s_tvalid = ($urandom_range(99) >= stall_pct);
            host.s_tdata  = val_of(acc);
            host.s_tlast  = (acc == 940) || (acc == bad_tlast);
            start = (c == extra_start);
            accept = host.s_tvalid && host.s_tready;
            if (host.s_tready && !host.s_tvalid) begin
                stalled = 1'b1;
                n_stall++;
            end
            @(posedge aclk);
            if (accept) acc++;
        end
        @(negedge aclk);
        check("busy_fall", 64'(busy), 64'd0);
        check("first_ready", 64'(first_rdy), 64'd4);
        check("word_count", 64'(seen), 64'd941);
        check("last_id", 64'(last_w[31:16]), 64'h0802);
        check("set_en_clean", 64'(set_bad), 64'd0);
    endtask

    initial begin
        int dc, ns, c2, nw2, wc2;
        int groups[4]  = '{1, 3, 3, 1};
        int neurons[4] = '{20, 20, 20, 3};
        int inputs[4]  = '{4, 7, 7, 7};
        logic [31:0] w2;
        for (int l = 0; l < 4; l++)
            for (int g = 0; g < groups[l]; g++)
                for (int n = 0; n < neurons[l]; n++)
                    for (int i = 0; i < inputs[l]; i++)
                        id_q.push_back(16'((256 << l) + g * 32 + n));

        host.s_tvalid  = 1'b0;
        host.s_tdata   = '0;
        host.s_tlast   = 1'b0;
        host2.s_tvalid = 1'b1;
        host2.s_tdata  = 16'h1234;
        host2.s_tlast  = 1'b1;

        repeat (3) @(negedge aclk);
        check("reset_vals", 64'({w_tdata, set_in, set_en, host.s_tready, busy, done, err}),
              64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("idle_vals", 64'({w_tdata, set_en, host.s_tready, busy, done, err}), 64'd0);

        run_load(0, -1, -1, -1, dc, ns);
        check("done_cycle", 64'(dc), 64'd1108);

        run_load(30, -1, -1, -1, dc, ns);
        check("done_stalled", 64'(dc), 64'(1108 + ns));

        run_load(0, 500, -1, -1, dc, ns);
        check("done_restart_ignored", 64'(dc), 64'd1108);

        run_load(0, -1, -1, 300, dc, ns);
        repeat (2) @(negedge aclk);
        check("reset_hold", 64'({w_tdata, set_en, host.s_tready, busy, done, err}), 64'd0);
        areset = 1'b0;
        @(negedge aclk);

        run_load(0, -1, 499, -1, dc, ns);
        check("done_bad_tlast", 64'(dc), 64'd1108);

        run_load(0, -1, -1, -1, dc, ns);
        check("done_after_err", 64'(dc), 64'd1108);

        // One-word table: SET_LOAD, 2 gap, word, neuron gap, 20 settle, SET_RUN in cycle 26.
        c2 = 0;
        nw2 = 0;
        wc2 = -1;
        w2 = '0;
        @(negedge aclk);
        start2 = 1'b1;
        @(posedge aclk);
        while (c2 < 100) begin
            @(negedge aclk);
            start2 = 1'b0;
            c2++;
            if (w_tdata2 != 32'd0) begin
                nw2++;
                w2 = w_tdata2;
                wc2 = c2;
            end
            if (done2) break;
        end
        check("small_word", 64'(w2), 64'h0100_1234);
        check("small_word_cycle", 64'(wc2), 64'd5);
        check("small_word_count", 64'(nw2), 64'd1);
        check("small_done_cycle", 64'(c2), 64'd26);
        check("small_run_mode", 64'({set_en2, set_in2, err2}), 64'({1'b1, 16'd1, 1'b0}));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
